// File: rtl/mod_display_comp2.sv
// Signed 6-bit value to 3-digit multiplexed seven-segment display.
// A small FSM converts the captured value to sign/tens/ones by repeated subtraction.
module mod_display_comp2 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] A_comp2,
    input  logic       load,
    output logic       busy,
    output logic       valid,
    output logic [3:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {IDLE, ABS, DIV, DONE} state_t;

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    state_t      r_state;
    logic [5:0]  r_a;
    logic        r_sign;
    logic [5:0]  r_rem;
    logic [1:0]  r_tens;
    logic        r_disp_sign;
    logic [1:0]  r_disp_tens;
    logic [3:0]  r_disp_ones;
    logic        r_valid;
    logic [PW-1:0] r_presc;
    logic [1:0]  r_dig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_sign      <= 1'b0;
            r_rem       <= '0;
            r_tens      <= '0;
            r_disp_sign <= 1'b0;
            r_disp_tens <= '0;
            r_disp_ones <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_a     <= A_comp2;
                        r_state <= ABS;
                    end
                end
                ABS: begin
                    // -32 negates to 6'b100000, which is exactly 32 as unsigned
                    r_sign  <= r_a[5];
                    r_rem   <= r_a[5] ? (~r_a + 6'd1) : r_a;
                    r_tens  <= '0;
                    r_state <= DIV;
                end
                DIV: begin
                    if (r_rem >= 6'd10) begin
                        r_rem  <= r_rem - 6'd10;
                        r_tens <= r_tens + 2'd1;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_disp_sign <= r_sign;
                    r_disp_tens <= r_tens;
                    r_disp_ones <= r_rem[3:0];
                    r_valid     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan runs regardless of FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_dig   <= '0;
        end else if (r_presc == P_LAST) begin
            r_presc <= '0;
            r_dig   <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        an  = 4'b1111;
        seg = 7'h7F;
        case (r_dig)
            2'd0: begin
                an  = 4'b1110;
                seg = f_seg(r_disp_ones);
            end
            2'd1: begin
                an  = 4'b1101;
                seg = (r_disp_tens == 2'd0) ? 7'h7F : f_seg({2'b00, r_disp_tens});
            end
            2'd2: begin
                an  = 4'b1011;
                seg = r_disp_sign ? 7'h3F : 7'h7F;
            end
            default: begin
                an  = 4'b1111;
                seg = 7'h7F;
            end
        endcase
    end

    assign busy  = (r_state != IDLE);
    assign valid = r_valid;

endmodule

// File: tb/tb_mod_display_comp2.sv
// Bench for mod_display_comp2: directed vector table, corner sequences and a
// randomized run, all checked against an arithmetic model of conversion and scan.
module tb_mod_display_comp2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] A_comp2;
    logic       load;
    logic       busy;
    logic       valid;
    logic [3:0] an;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    mod_display_comp2 #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A_comp2 (A_comp2),
        .load    (load),
        .busy    (busy),
        .valid   (valid),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG_CODE [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: cycles since reset, remaining busy cycles, pending and shown digits
    int m_cyc, m_left, m_pend, m_shown;
    bit m_valid;

    typedef struct {
        logic [5:0] a;
        int         busy_cycles;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] sgn;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic ld, input logic [5:0] a);
        int v, mag;
        if (!rn) begin
            m_cyc = 0; m_left = 0; m_valid = 0; m_shown = 0;
        end else begin
            m_cyc++;
            if (m_left == 0) begin
                if (ld) begin
                    v = int'($signed(a));
                    m_pend = v;
                    mag = (v < 0) ? -v : v;
                    m_left = mag / 10 + 3;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_shown = m_pend;
                    m_valid = 1;
                end
            end
        end
    endtask

    task automatic model_check();
        int idx, mag, t, o;
        logic [3:0] ean;
        logic [6:0] eseg;
        mag = (m_shown < 0) ? -m_shown : m_shown;
        t = mag / 10;
        o = mag % 10;
        idx = (m_cyc / 4) % 3;
        if (idx == 0) begin
            ean = 4'b1110; eseg = SEG_CODE[o];
        end else if (idx == 1) begin
            ean = 4'b1101; eseg = (t == 0) ? 7'h7F : SEG_CODE[t];
        end else begin
            ean = 4'b1011; eseg = (m_shown < 0) ? 7'h3F : 7'h7F;
        end
        chk("busy", int'(busy), int'(m_left != 0));
        chk("valid", int'(valid), int'(m_valid));
        chk("an", int'(an), int'(ean));
        chk("seg", int'(seg), int'(eseg));
    endtask

    task automatic step(input logic rn, input logic ld, input logic [5:0] a);
        rst_n = rn; load = ld; A_comp2 = a;
        @(posedge clk);
        model_edge(rn, ld, a);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b0, 6'd0);
    endtask

    // Idle for a full scan period and collect the segment code seen on each digit
    task automatic capture(output logic [6:0] o, output logic [6:0] t, output logic [6:0] s);
        o = 'x; t = 'x; s = 'x;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 6'd0);
            if (an == 4'b1110) o = seg;
            else if (an == 4'b1101) t = seg;
            else if (an == 4'b1011) s = seg;
        end
    endtask

    task automatic count_busy(output int bc);
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            step(1'b1, 1'b0, 6'd0);
        end
    endtask

    initial begin
        logic [6:0] o, t, s;
        int bc;
        rst_n = 1'b0; load = 1'b0; A_comp2 = '0;
        m_cyc = 0; m_left = 0; m_pend = 0; m_shown = 0; m_valid = 0;

        vecs[0] = '{6'b100000, 6, 7'h24, 7'h30, 7'h3F};
        vecs[1] = '{6'b011111, 6, 7'h79, 7'h30, 7'h7F};
        vecs[2] = '{6'b111111, 3, 7'h79, 7'h7F, 7'h3F};
        vecs[3] = '{6'b000000, 3, 7'h40, 7'h7F, 7'h7F};
        vecs[4] = '{6'b001010, 4, 7'h40, 7'h79, 7'h7F};
        vecs[5] = '{6'b110110, 4, 7'h40, 7'h79, 7'h3F};
        vecs[6] = '{6'b001001, 3, 7'h10, 7'h7F, 7'h7F};
        vecs[7] = '{6'b100111, 5, 7'h12, 7'h24, 7'h3F};

        // Reset state and idle scan
        do_reset();
        chk("reset_an", int'(an), 4'b1110);
        chk("reset_seg", int'(seg), 7'h40);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 6'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            step(1'b1, 1'b1, vecs[v].a);
            count_busy(bc);
            chk("vec_busy_len", bc, vecs[v].busy_cycles);
            chk("vec_valid", int'(valid), 1);
            capture(o, t, s);
            chk("vec_ones", int'(o), int'(vecs[v].ones));
            chk("vec_tens", int'(t), int'(vecs[v].tens));
            chk("vec_sign", int'(s), int'(vecs[v].sgn));
        end

        // Second load during conversion is ignored
        do_reset();
        step(1'b1, 1'b1, 6'b100000);
        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b1, 6'b000101);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'd0);
        capture(o, t, s);
        chk("ignore_ones", int'(o), 7'h24);
        chk("ignore_tens", int'(t), 7'h30);
        chk("ignore_sign", int'(s), 7'h3F);

        // Reset in the second DIV cycle aborts, then a fresh conversion of 0
        do_reset();
        step(1'b1, 1'b1, 6'b100000);
        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b0, 6'd0);
        step(1'b0, 1'b1, 6'b000101);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_an", int'(an), 4'b1110);
        chk("abort_seg", int'(seg), 7'h40);
        step(1'b1, 1'b1, 6'b000000);
        count_busy(bc);
        chk("abort_reload_len", bc, 3);
        capture(o, t, s);
        chk("abort_reload_ones", int'(o), 7'h40);

        // load held high restarts on the first IDLE cycle after DONE
        do_reset();
        step(1'b1, 1'b1, 6'b000101);
        step(1'b1, 1'b1, 6'b000101);
        step(1'b1, 1'b1, 6'b000101);
        step(1'b1, 1'b1, 6'b000101);
        chk("held_gap", int'(busy), 0);
        step(1'b1, 1'b1, 6'b000101);
        chk("held_restart", int'(busy), 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 6'($urandom_range(0, 63)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_display_comp2.md
MOD_DISPLAY_COMP2 -- requirements
Module: mod_display_comp2

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles each digit stays lit per scan step (minimum 1).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: A_comp2  input  6  signed two's-complement value from the complement converter, range -32..+31.
REQ-005 Port: load  input  1  capture strobe; sampled each rising edge.
REQ-006 Port: busy  output  1  high while a captured value is being converted.
REQ-007 Port: valid  output  1  high once at least one value has been converted since reset.
REQ-008 Port: an  output  4  digit enables, active-low; an[3] unused and always 1.
REQ-009 Port: seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 The design SHALL use one clock, clk, with a synchronous active-low reset, rst_n.

Function
REQ-011 FSM states SHALL be IDLE, ABS, DIV and DONE; busy SHALL be 1 in every state except IDLE.
REQ-012 In IDLE, load=1 SHALL capture A_comp2 and go to ABS; load SHALL be ignored in every other state, with no queuing.
REQ-013 ABS (1 cycle) SHALL latch sign = A[5] and mag = |A| as 6-bit unsigned (-32 -> 32, no overflow), set tens=0 and rem=mag, then go to DIV.
REQ-014 DIV (one cycle per step): if rem>=10, it SHALL set rem-=10 and tens+=1 and stay; otherwise it SHALL go to DONE.
REQ-015 DONE (1 cycle) SHALL copy sign, tens and rem into the display registers, set valid=1, and go to IDLE.
REQ-016 Latency: busy SHALL be high for exactly tens+3 cycles, starting the cycle after load is accepted.
REQ-017 The display registers SHALL change only in DONE; during conversion the previous value SHALL stay displayed.
REQ-018 The scan prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->0.
REQ-019 Digit index 0 SHALL drive an=1110 with the ones digit, index 1 an=1101 with the tens digit, and index 2 an=1011 with the sign digit.
REQ-020 The sign digit SHALL be minus (seg=0111111) when sign=1 and blank (1111111) otherwise.
REQ-021 The tens digit SHALL be blank when tens=0; the ones digit SHALL always be shown.
REQ-022 Segment codes 0..9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
REQ-023 Scanning SHALL run continuously, independent of FSM state.
REQ-024 load held high SHALL start a new conversion on the first IDLE cycle after DONE.

Reset
REQ-025 With rst_n=0 at a rising edge, on that edge: FSM SHALL go to IDLE; busy=0; valid=0; sign=0; tens=0; ones=0; prescaler=0; digit index=0.
REQ-026 After reset the outputs SHALL be an=1110 and seg=1000000.
REQ-027 Reset SHALL take priority over load in the same cycle.
REQ-028 Reset mid-conversion SHALL abort the conversion and discard the captured value.

Verification (REFRESH_DIV=4)
REQ-029 rst_n=0 for 2 cycles, then released -> busy=0, valid=0, an=1110 and seg=40 held for 4 cycles, then an=1101 (seg=7F), then an=1011 (seg=7F), then back to 1110.
REQ-030 load 1 cycle with A=100000 (-32) -> busy high 6 cycles, valid=1; the scan then shows ones=24 (2), tens=30 (3), sign=3F.
REQ-031 load with A=011111 (+31) -> busy 6 cycles; ones=79, tens=30, sign=7F.
REQ-032 load with A=111111 (-1) -> busy 3 cycles; ones=79, tens blank 7F, sign=3F.
REQ-033 load A=100000, then load A=000101 two cycles later -> the second load is ignored; the display ends as -32.
REQ-034 load A=100000, then rst_n=0 during the second DIV cycle -> next edge busy=0, valid=0, display returns to the REQ-026 reset state; a subsequent load A=000000 -> busy 3 cycles, ones=40.
